// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and region helpers
// Shared by vga_timing_gen (optional pix_ce via VGA_TIMING_CE_EN) and vga_axis_counter.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 16;

  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_first(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_last(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrap counter, registered sync decode, wrap flag
// Region order along the axis is active, front porch, sync, back porch.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             active_nxt,
  output logic             wrap_out
);

  localparam int               TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(sync_first(ACTIVE, FP));
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(sync_last(ACTIVE, FP, SYNC));
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;

  // Decode from the next count so sync lines up with the count it is stored beside.
  always_comb begin
    count_d = count_q;
    if (advance) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
    sync_d = ((count_d >= SYNC_LO) && (count_d <= SYNC_HI)) ? POL : ~POL;
  end

  // Reset parks on the last position (back porch), where sync is inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= LAST;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count      = count_q;
  assign sync       = sync_q;
  assign active_nxt = (count_d < ACT_END);
  assign wrap_out   = advance && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator (top)
// Define VGA_TIMING_CE_EN to add the pix_ce pixel clock enable port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk_25Mhz,
  input  logic             rst,
`ifdef VGA_TIMING_CE_EN
  input  logic             pix_ce,
`endif
  output logic [CNT_W-1:0] H_Count_Value,
  output logic [CNT_W-1:0] V_Count_Value,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
    $error("vga_timing_gen: porch and sync widths must be at least 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  logic ce;
`ifdef VGA_TIMING_CE_EN
  assign ce = pix_ce;
`else
  assign ce = 1'b1;
`endif

  logic h_wrap, v_wrap, h_act_nxt, v_act_nxt;
  logic video_on_q, video_on_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk        (clk_25Mhz),
    .rst        (rst),
    .advance    (ce),
    .count      (H_Count_Value),
    .sync       (hsync),
    .active_nxt (h_act_nxt),
    .wrap_out   (h_wrap)
  );

  // V steps only as H wraps, so vsync can change only where H becomes 0.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk        (clk_25Mhz),
    .rst        (rst),
    .advance    (h_wrap),
    .count      (V_Count_Value),
    .sync       (vsync),
    .active_nxt (v_act_nxt),
    .wrap_out   (v_wrap)
  );

  // Strobes are held while ce is low so they mark a pixel rather than a clock.
  always_comb begin
    video_on_d    = h_act_nxt && v_act_nxt;
    line_start_d  = ce ? h_wrap : line_start_q;
    frame_start_d = ce ? v_wrap : frame_start_q;
  end

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
